bp_be_long_wb_buffer: RTL and testbench



---
 rtl/bp_be_long_wb_buffer.sv | 168 ++++++++++++++++
 tb/tb_bp_be_long_wb_buffer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_long_wb_buffer.sv
// Buffers long-latency (divide) pipe results until the integer regfile write port is free.
// Also tracks pending destination registers to provide an issue stall and a long-pipe ready signal.
module bp_be_long_wb_buffer #(
    parameter int reg_addr_width_p = 5,
    parameter int dword_width_p    = 64,
    parameter int els_p            = 2
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,

    input  logic                        issue_v_i,
    input  logic [reg_addr_width_p-1:0] issue_rd_addr_i,
    input  logic                        flush_i,

    input  logic                        long_v_i,
    input  logic [reg_addr_width_p-1:0] long_rd_addr_i,
    input  logic [dword_width_p-1:0]    long_rd_data_i,

    input  logic                        main_wb_v_i,
    output logic                        wb_v_o,
    output logic [reg_addr_width_p-1:0] wb_rd_addr_o,
    output logic [dword_width_p-1:0]    wb_rd_data_o,

    output logic                        ready_o,

    input  logic [reg_addr_width_p-1:0] dep_rs1_addr_i,
    input  logic [reg_addr_width_p-1:0] dep_rs2_addr_i,
    input  logic [reg_addr_width_p-1:0] dep_rd_addr_i,
    output logic                        dep_stall_o,

    output logic                        empty_o
);

    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);
    localparam logic [cnt_w_lp-1:0] full_cnt_lp    = cnt_w_lp'(els_p);
    localparam logic [cnt_w_lp-1:0] almost_cnt_lp  = cnt_w_lp'(els_p - 1);
    localparam logic [ptr_w_lp-1:0] last_ptr_lp    = ptr_w_lp'(els_p - 1);

    logic                        inflight_v_q, inflight_v_d;
    logic [reg_addr_width_p-1:0] inflight_rd_q, inflight_rd_d;

    logic [reg_addr_width_p-1:0] rd_mem_q   [els_p];
    logic [reg_addr_width_p-1:0] rd_mem_d   [els_p];
    logic [dword_width_p-1:0]    data_mem_q [els_p];
    logic [dword_width_p-1:0]    data_mem_d [els_p];
    logic [els_p-1:0]            valid_q, valid_d;

    logic [ptr_w_lp-1:0]         rptr_q, rptr_d;
    logic [ptr_w_lp-1:0]         wptr_q, wptr_d;
    logic [cnt_w_lp-1:0]         count_q, count_d;

    logic                        fifo_empty;
    logic                        fifo_full;
    logic                        enq;
    logic                        deq;
    logic                        rs1_hit, rs2_hit, rd_hit;

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == full_cnt_lp);
        deq        = ~fifo_empty & ~main_wb_v_i;
        // A full buffer can still accept when its head leaves on the same edge.
        enq        = long_v_i & (long_rd_addr_i != '0) & (~fifo_full | deq);
    end

    always_comb begin
        wb_v_o       = deq;
        wb_rd_addr_o = '0;
        wb_rd_data_o = '0;
        if (!fifo_empty) begin
            wb_rd_addr_o = rd_mem_q[rptr_q];
            wb_rd_data_o = data_mem_q[rptr_q];
        end
    end

    always_comb begin
        inflight_v_d  = inflight_v_q;
        inflight_rd_d = inflight_rd_q;
        if (issue_v_i && (issue_rd_addr_i != '0)) begin
            inflight_v_d  = 1'b1;
            inflight_rd_d = issue_rd_addr_i;
        end else if (long_v_i || flush_i) begin
            inflight_v_d  = 1'b0;
        end
    end

    always_comb begin
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        valid_d    = valid_q;
        rptr_d     = rptr_q;
        wptr_d     = wptr_q;
        count_d    = count_q;

        if (deq) begin
            valid_d[rptr_q] = 1'b0;
            rptr_d          = (rptr_q == last_ptr_lp) ? '0 : rptr_q + 1'b1;
        end
        // The enqueue comes after the dequeue so a full-buffer pass-through re-validates the slot.
        if (enq) begin
            rd_mem_d[wptr_q]   = long_rd_addr_i;
            data_mem_d[wptr_q] = long_rd_data_i;
            valid_d[wptr_q]    = 1'b1;
            wptr_d             = (wptr_q == last_ptr_lp) ? '0 : wptr_q + 1'b1;
        end

        if (enq && !deq) begin
            count_d = count_q + 1'b1;
        end else if (deq && !enq) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        rs1_hit = (dep_rs1_addr_i != '0) & inflight_v_q & (dep_rs1_addr_i == inflight_rd_q);
        rs2_hit = (dep_rs2_addr_i != '0) & inflight_v_q & (dep_rs2_addr_i == inflight_rd_q);
        rd_hit  = (dep_rd_addr_i  != '0) & inflight_v_q & (dep_rd_addr_i  == inflight_rd_q);
        for (int i = 0; i < els_p; i++) begin
            if (valid_q[i]) begin
                rs1_hit = rs1_hit | ((dep_rs1_addr_i != '0) & (dep_rs1_addr_i == rd_mem_q[i]));
                rs2_hit = rs2_hit | ((dep_rs2_addr_i != '0) & (dep_rs2_addr_i == rd_mem_q[i]));
                rd_hit  = rd_hit  | ((dep_rd_addr_i  != '0) & (dep_rd_addr_i  == rd_mem_q[i]));
            end
        end
        dep_stall_o = rs1_hit | rs2_hit | rd_hit;
    end

    // Only one long op is outstanding, so ready just needs a guaranteed slot for its result.
    always_comb begin
        ready_o = ~inflight_v_q
                & (count_q < full_cnt_lp)
                & ((count_q < almost_cnt_lp) | wb_v_o);
        empty_o = ~inflight_v_q & fifo_empty;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            inflight_v_q  <= 1'b0;
            inflight_rd_q <= '0;
            valid_q       <= '0;
            rptr_q        <= '0;
            wptr_q        <= '0;
            count_q       <= '0;
            for (int i = 0; i < els_p; i++) begin
                rd_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
            end
        end else begin
            inflight_v_q  <= inflight_v_d;
            inflight_rd_q <= inflight_rd_d;
            valid_q       <= valid_d;
            rptr_q        <= rptr_d;
            wptr_q        <= wptr_d;
            count_q       <= count_d;
            rd_mem_q      <= rd_mem_d;
            data_mem_q    <= data_mem_d;
        end
    end

    a_no_issue_while_inflight: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) !(issue_v_i && inflight_v_q));

    a_no_enqueue_when_full: assert property (
        @(posedge clk_i) disable iff (!reset_n_i)
        !(long_v_i && (long_rd_addr_i != '0) && fifo_full && !deq));

endmodule

// File: tb/tb_bp_be_long_wb_buffer.sv
// Bench for bp_be_long_wb_buffer: directed scenarios then randomized traffic,
// all checked against a queue-based reference model of the pending results.
module tb_bp_be_long_wb_buffer;

    localparam int AW  = 5;
    localparam int DW  = 64;
    localparam int ELS = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          issue_v;
    logic [AW-1:0] issue_rd;
    logic          flush;
    logic          long_v;
    logic [AW-1:0] long_rd;
    logic [DW-1:0] long_data;
    logic          main_wb_v;
    logic          wb_v;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          ready;
    logic [AW-1:0] dep_rs1, dep_rs2, dep_rd;
    logic          dep_stall;
    logic          empty;

    int checks = 0;
    int errors = 0;

    // Reference model: pending results in order, plus the single in-flight rd.
    logic [AW-1:0] mRd[$];
    logic [DW-1:0] mData[$];
    bit            mInflight;
    logic [AW-1:0] mInflightRd;

    // Random long-pipe model.
    bit            pipeBusy;
    int            pipeCnt;
    logic [AW-1:0] pipeRd;

    always #5 clk = ~clk;

    bp_be_long_wb_buffer #(
        .reg_addr_width_p(AW),
        .dword_width_p(DW),
        .els_p(ELS)
    ) dut (
        .clk_i(clk),
        .reset_n_i(reset_n),
        .issue_v_i(issue_v),
        .issue_rd_addr_i(issue_rd),
        .flush_i(flush),
        .long_v_i(long_v),
        .long_rd_addr_i(long_rd),
        .long_rd_data_i(long_data),
        .main_wb_v_i(main_wb_v),
        .wb_v_o(wb_v),
        .wb_rd_addr_o(wb_rd),
        .wb_rd_data_o(wb_data),
        .ready_o(ready),
        .dep_rs1_addr_i(dep_rs1),
        .dep_rs2_addr_i(dep_rs2),
        .dep_rd_addr_i(dep_rd),
        .dep_stall_o(dep_stall),
        .empty_o(empty)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic bit depHit(input logic [AW-1:0] a);
        if (a == '0) return 1'b0;
        if (mInflight && a == mInflightRd) return 1'b1;
        foreach (mRd[i]) if (mRd[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit modelReady(input bit mw);
        bit wbExp;
        wbExp = (mRd.size() != 0) && !mw;
        return !mInflight && (mRd.size() < ELS) && ((mRd.size() < ELS - 1) || wbExp);
    endfunction

    // Drives one cycle of inputs after the falling edge, checks every output
    // against the model, then advances the model to the state after the next rising edge.
    task automatic applyStimulus(input bit iv, input logic [AW-1:0] ird, input bit fl,
                                 input bit lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
                                 input bit mw, input logic [AW-1:0] d1, input logic [AW-1:0] d2,
                                 input logic [AW-1:0] d3);
        bit            expWb;
        logic [AW-1:0] expRd;
        logic [DW-1:0] expData;
        @(negedge clk);
        issue_v   = iv;
        issue_rd  = ird;
        flush     = fl;
        long_v    = lv;
        long_rd   = lrd;
        long_data = ld;
        main_wb_v = mw;
        dep_rs1   = d1;
        dep_rs2   = d2;
        dep_rd    = d3;
        #1;
        expWb   = (mRd.size() != 0) && !mw;
        expRd   = (mRd.size() != 0) ? mRd[0] : '0;
        expData = (mRd.size() != 0) ? mData[0] : '0;
        checkOutput("wb_v", 64'(wb_v), 64'(expWb));
        checkOutput("wb_rd", 64'(wb_rd), 64'(expRd));
        checkOutput("wb_data", wb_data, expData);
        checkOutput("ready", 64'(ready), 64'(modelReady(mw)));
        checkOutput("dep_stall", 64'(dep_stall), 64'(depHit(d1) | depHit(d2) | depHit(d3)));
        checkOutput("empty", 64'(empty), 64'(!mInflight && mRd.size() == 0));
        if (expWb) begin
            void'(mRd.pop_front());
            void'(mData.pop_front());
        end
        if (lv && lrd != '0 && mRd.size() < ELS) begin
            mRd.push_back(lrd);
            mData.push_back(ld);
        end
        if (iv && ird != '0) begin
            mInflight   = 1'b1;
            mInflightRd = ird;
        end else if (lv || fl) begin
            mInflight = 1'b0;
        end
    endtask

    task automatic idle(input bit mw, input logic [AW-1:0] d1);
        applyStimulus(0, 0, 0, 0, 0, 0, mw, d1, 0, 0);
    endtask

    initial begin
        bit            iv, fl, lv, mw, deliver;
        logic [AW-1:0] ird, lrd, d1, d2, d3;
        logic [DW-1:0] ld;

        reset_n   = 1'b0;
        issue_v   = 1'b0;
        issue_rd  = '0;
        flush     = 1'b0;
        long_v    = 1'b0;
        long_rd   = '0;
        long_data = '0;
        main_wb_v = 1'b0;
        dep_rs1   = '0;
        dep_rs2   = '0;
        dep_rd    = '0;
        mInflight = 1'b0;
        mInflightRd = '0;
        pipeBusy  = 1'b0;
        pipeCnt   = 0;
        pipeRd    = '0;

        #2;
        checkOutput("rst_wb_v", 64'(wb_v), 64'd0);
        checkOutput("rst_ready", 64'(ready), 64'd1);
        checkOutput("rst_empty", 64'(empty), 64'd1);
        checkOutput("rst_stall", 64'(dep_stall), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        idle(0, 0);
        idle(0, 0);

        // Basic issue -> result -> writeback.
        applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 5);
        applyStimulus(0, 0, 0, 1, 5, 64'h1234, 0, 5, 0, 0);
        idle(0, 5);
        idle(0, 5);

        // Main pipeline holds the port for three cycles.
        applyStimulus(1, 6, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 6, 64'hAAAA_5555, 1, 6, 0, 0);
        idle(1, 6);
        idle(1, 6);
        idle(1, 0);
        idle(0, 6);
        idle(0, 6);

        // Fill both entries under main priority, then drain in order.
        applyStimulus(0, 0, 0, 1, 3, 64'h3333, 1, 0, 3, 0);
        applyStimulus(0, 0, 0, 1, 7, 64'h7777, 1, 0, 0, 7);
        idle(1, 7);
        idle(0, 3);
        idle(0, 7);
        idle(0, 0);

        // Flush clears the tracker; a committed entry still drains.
        applyStimulus(1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 4, 64'h4444, 1, 9, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 1, 9, 0, 0);
        idle(1, 9);
        idle(0, 4);
        idle(0, 4);

        // Results to x0 are discarded.
        applyStimulus(0, 0, 0, 1, 0, 64'hDEAD, 0, 0, 0, 0);
        idle(0, 0);

        // Asynchronous reset while an entry is buffered.
        applyStimulus(0, 0, 0, 1, 11, 64'hBBBB, 1, 11, 0, 0);
        idle(1, 11);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_wb_v", 64'(wb_v), 64'd0);
        checkOutput("async_wb_rd", 64'(wb_rd), 64'd0);
        checkOutput("async_wb_data", wb_data, 64'd0);
        checkOutput("async_ready", 64'(ready), 64'd1);
        checkOutput("async_stall", 64'(dep_stall), 64'd0);
        checkOutput("async_empty", 64'(empty), 64'd1);
        mRd.delete();
        mData.delete();
        mInflight = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized traffic with a one-op-at-a-time long pipe and occasional stray results.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            mw      = ($urandom % 3) == 0;
            fl      = ($urandom % 10) == 0;
            ld      = {$urandom, $urandom};
            lrd     = AW'($urandom_range(0, 7));
            lv      = 1'b0;
            iv      = 1'b0;
            deliver = pipeBusy && pipeCnt == 0;
            if (deliver) begin
                lv  = 1'b1;
                lrd = pipeRd;
            end else if (!pipeBusy && ($urandom % 8) == 0 &&
                         (mRd.size() < ELS || (mRd.size() != 0 && !mw))) begin
                lv = 1'b1;
            end
            ird = AW'($urandom_range(0, 7));
            if (!pipeBusy && !lv && modelReady(mw) && ($urandom % 3) == 0) iv = 1'b1;
            d1 = AW'($urandom_range(0, 7));
            d2 = AW'($urandom_range(0, 7));
            d3 = AW'($urandom_range(0, 7));
            applyStimulus(iv, ird, fl, lv, lrd, ld, mw, d1, d2, d3);
            if (deliver) pipeBusy = 1'b0;
            else if (pipeBusy && fl) pipeBusy = 1'b0;
            else if (pipeBusy) pipeCnt--;
            if (iv) begin
                pipeBusy = 1'b1;
                pipeCnt  = $urandom_range(0, 3);
                pipeRd   = ird;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
